mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/wait_counter.sv | 17 +
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default access length for mem_arbiter.
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int WAIT_CYCLES_DEF = 2;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: 4-bit loadable down-counter with zero flag and synchronous clear.
module wait_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clock) begin
    if (clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign zero = cnt == 4'd0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter onto a single fixed-latency memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              rw0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              rw1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);
  logic [1:0] state;
  logic grant, last_grant, zero, win, start;
  // On a tie the port that did not win last time is served.
  assign win = (req0 && req1) ? ~last_grant : req1;
  assign start = state == IDLE && (req0 || req1);
  wait_counter u_wait (
    .clock(clock),
    .clear(reset),
    .load(start),
    .load_val(LOAD),
    .dec(state == ACCESS),
    .zero(zero)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b1;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_rw <= 1'b1;
      rdata <= '0;
    end else if (start) begin
      state <= ACCESS;
      grant <= win;
      last_grant <= win;
      mem_addr <= win ? addr1 : addr0;
      mem_wdata <= win ? wdata1 : wdata0;
      mem_rw <= win ? rw1 : rw0;
    end else if (state == ACCESS) begin
      if (zero) begin
        state <= DONE;
        if (mem_rw) rdata <= mem_rdata;
      end
    end else begin
      state <= IDLE;
    end
  end
  assign mem_en = state == ACCESS;
  assign ack0 = state == DONE && !grant;
  assign ack1 = state == DONE && grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at WAIT_CYCLES 2 and 1.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset, req0, rw0, req1, rw1;
  logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;
  logic ack0, ack1, mem_en, mem_rw;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic b_ack0, b_ack1, b_mem_en, b_mem_rw;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .rw0(rw0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .rw1(rw1), .ack1(ack1),
    .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .rw0(rw0), .ack0(b_ack0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .rw1(rw1), .ack1(b_ack1),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rw(b_mem_rw), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    {req0, rw0, req1, rw1} = 4'b0101;
    {addr0, wdata0, addr1, wdata1, mem_rdata} = '0;
    do_reset();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_rw", mem_rw, 1);

    // single read from port 0
    req0 = 1; addr0 = 32'h10; rw0 = 1; mem_rdata = 32'hDEADBEEF;
    step();
    check("s1_en_c1", mem_en, 1);
    check("s1_addr", mem_addr, 32'h10);
    check("s1_rw", mem_rw, 1);
    check("s1_noack_c1", ack0, 0);
    step();
    check("s1_en_c2", mem_en, 1);
    check("s1_noack_c2", ack0, 0);
    step();
    check("s1_en_done", mem_en, 0);
    check("s1_ack0", ack0, 1);
    check("s1_ack1", ack1, 0);
    check("s1_rdata", rdata, 32'hDEADBEEF);
    req0 = 0;
    step();
    check("s1_ack0_off", ack0, 0);

    // held tie alternates starting at port 0 after reset
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200; rw0 = 1; rw1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("s2_addr%0d", k), mem_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      step();
      step();
      check($sformatf("s2_ack0_%0d", k), ack0, (k % 2 == 0) ? 1 : 0);
      check($sformatf("s2_ack1_%0d", k), ack1, (k % 2 == 1) ? 1 : 0);
      step();
      check($sformatf("s2_idle_acks%0d", k), {ack0, ack1}, 0);
      check($sformatf("s2_idle_en%0d", k), mem_en, 0);
    end
    req0 = 0; req1 = 0;

    // write from port 1 leaves rdata alone
    req1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678; rw1 = 0; mem_rdata = 32'h55555555;
    step();
    check("s3_rw_c1", mem_rw, 0);
    check("s3_wdata_c1", mem_wdata, 32'h12345678);
    check("s3_addr", mem_addr, 32'h20);
    step();
    check("s3_rw_c2", mem_rw, 0);
    check("s3_en_c2", mem_en, 1);
    step();
    check("s3_ack1", ack1, 1);
    check("s3_ack0", ack0, 0);
    check("s3_rdata", rdata, 32'hDEADBEEF);
    req1 = 0;
    step();
    check("s3_ack1_off", ack1, 0);

    // request dropped after grant still completes
    req0 = 1; addr0 = 32'h30; rw0 = 1;
    step();
    req0 = 0;
    check("s4_en", mem_en, 1);
    step();
    step();
    check("s4_ack0", ack0, 1);
    step();
    check("s4_ack0_off", ack0, 0);
    step();
    check("s4_no_retrig", mem_en, 0);

    // reset mid-access abandons the transaction
    req0 = 1; addr0 = 32'h44;
    step();
    step();
    check("s5_en_c2", mem_en, 1);
    reset = 1; req0 = 0;
    step();
    check("s5_en_rst", mem_en, 0);
    check("s5_ack_rst", {ack0, ack1}, 0);
    check("s5_addr_rst", mem_addr, 0);
    check("s5_rw_rst", mem_rw, 1);
    reset = 0;
    step();
    check("s5_no_ack", {ack0, ack1}, 0);
    req0 = 1; req1 = 1; addr0 = 32'h40; addr1 = 32'h50;
    step();
    check("s5_tie_port0", mem_addr, 32'h40);
    req0 = 0; req1 = 0;
    step();
    step();
    step();

    // single-cycle access with a held request
    do_reset();
    req0 = 1; addr0 = 32'h60; rw0 = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    check("s6_en", b_mem_en, 1);
    check("s6_addr", b_mem_addr, 32'h60);
    step();
    check("s6_ack0", b_ack0, 1);
    check("s6_en_done", b_mem_en, 0);
    check("s6_rdata", b_rdata, 32'hA5A5A5A5);
    step();
    check("s6_idle", {b_ack0, b_mem_en}, 0);
    step();
    check("s6_regrant", b_mem_en, 1);
    step();
    check("s6_ack0_again", b_ack0, 1);
    req0 = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
